// File: rtl/fnd_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner for a two-pair (hh/ll) time display.
// Optional build macro: FND_LEAD_ZERO_BLANK_EN blanks the leftmost digit when it is a leading zero.
module fnd_scan_ctrl #(
    parameter int SYS_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] digit_h,
    input  logic [6:0] digit_l,
    input  logic       dot,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int PERIOD = SYS_HZ / SCAN_HZ;
    localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;
    logic          scan_tick;
    logic [1:0]    idx;
    logic          started;
    logic [6:0]    sh_h;
    logic [6:0]    sh_l;
    logic          sh_dot;

    logic [3:0]    h_tens;
    logic [3:0]    h_ones;
    logic [3:0]    l_tens;
    logic [3:0]    l_ones;
    logic [3:0]    cur_digit;
    logic [6:0]    cur_code;
    logic          cur_dp;

    // Saturate at 99, then split into {tens, ones} by repeated subtraction.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [6:0] r;
        logic [3:0] t;
        r = (v > 7'd99) ? 7'd99 : v;
        t = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (r >= 7'd10) begin
                r = r - 7'd10;
                t = t + 4'd1;
            end
        end
        return {t, r[3:0]};
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign scan_tick = (cnt == LAST);

    // The first tick after reset acts as a frame start: it captures the inputs
    // and lights digit 0 without advancing the index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            idx     <= 2'd0;
            started <= 1'b0;
            sh_h    <= 7'd0;
            sh_l    <= 7'd0;
            sh_dot  <= 1'b0;
        end else begin
            cnt <= scan_tick ? '0 : cnt + 1'b1;
            if (scan_tick) begin
                started <= 1'b1;
                if (started) begin
                    idx <= idx + 2'd1;
                end
                if (!started || idx == 2'd3) begin
                    sh_h   <= digit_h;
                    sh_l   <= digit_l;
                    sh_dot <= dot;
                end
            end
        end
    end

    assign {h_tens, h_ones} = to_bcd(sh_h);
    assign {l_tens, l_ones} = to_bcd(sh_l);

    always_comb begin
        cur_digit = l_ones;
        case (idx)
            2'd0:    cur_digit = l_ones;
            2'd1:    cur_digit = l_tens;
            2'd2:    cur_digit = h_ones;
            default: cur_digit = h_tens;
        endcase
        cur_code = decode(cur_digit);
`ifdef FND_LEAD_ZERO_BLANK_EN
        if (idx == 2'd3 && h_tens == 4'd0) begin
            cur_code = 7'h7F;
        end
`endif
        cur_dp = ~((idx == 2'd2) & sh_dot);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg <= 8'hFF;
            an  <= 4'b1111;
        end else if (started) begin
            seg <= {cur_dp, cur_code};
            an  <= ~(4'b0001 << idx);
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// [TB] Self-checking bench for fnd_scan_ctrl with an 8-clock scan step.
// Expectations come from a time-based model: edges since reset release select the digit and frame.
module tb_fnd_scan_ctrl;

    localparam int SYS_HZ  = 8;
    localparam int SCAN_HZ = 1;

    localparam logic [7:0] CODES [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    localparam logic [3:0] AN_SEQ [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] digit_h = 7'd0;
    logic [6:0] digit_l = 7'd0;
    logic       dot = 1'b0;
    logic [7:0] seg;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;

    int n = 0;
    int cap_h[$];
    int cap_l[$];
    bit cap_d[$];

    always #5 clk = ~clk;

    fnd_scan_ctrl #(.SYS_HZ(SYS_HZ), .SCAN_HZ(SCAN_HZ)) dut (
        .clk(clk), .reset(reset), .digit_h(digit_h), .digit_l(digit_l),
        .dot(dot), .seg(seg), .an(an)
    );

    // Reference timeline: frame f is captured on edge 8+32f; digit k is shown from edge 9+8k.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            n = 0;
            cap_h.delete();
            cap_l.delete();
            cap_d.delete();
        end else begin
            n++;
            if (n >= 8 && (n - 8) % 32 == 0) begin
                cap_h.push_back(int'(digit_h));
                cap_l.push_back(int'(digit_l));
                cap_d.push_back(dot);
            end
        end
    end

    function automatic logic [7:0] exp_seg(int d, int h, int l, bit dt);
        int hv, lv, val;
        logic [7:0] s;
        hv = (h > 99) ? 99 : h;
        lv = (l > 99) ? 99 : l;
        case (d)
            0:       val = lv % 10;
            1:       val = lv / 10;
            2:       val = hv % 10;
            default: val = hv / 10;
        endcase
        s = CODES[val];
        if (d == 2 && dt) s = s & 8'h7F;
`ifdef FND_LEAD_ZERO_BLANK_EN
        if (d == 3 && hv < 10) s = 8'hFF;
`endif
        return s;
    endfunction

    task automatic model_expect(output logic [3:0] ea, output logic [7:0] es);
        int k, f, d;
        if (n < 9) begin
            ea = 4'b1111;
            es = 8'hFF;
        end else begin
            k = (n - 9) / 8;
            f = k / 4;
            d = k % 4;
            ea = AN_SEQ[d];
            if (f < cap_h.size()) es = exp_seg(d, cap_h[f], cap_l[f], cap_d[f]);
            else                  es = 8'hXX;
        end
    endtask

    task automatic sync_capture();
        int budget;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!(n >= 8 && (n - 8) % 32 == 0) && budget < 80);
        if (budget >= 80) begin
            checks++;
            errors++;
            $display("[TB] FAIL sync_capture: no frame start seen within %0d clocks (n=%0d)", budget, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        digit_h = 7'd12;
        digit_l = 7'd34;
        dot = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (an !== 4'b1111 || seg !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL reset_dark: an=%b seg=%h, want an=1111 seg=ff", an, seg);
        end
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (an !== 4'b1111 || seg !== 8'hFF) begin
                errors++;
                $display("[TB] FAIL pre_tick_dark[%0d]: an=%b seg=%h, want an=1111 seg=ff", i, an, seg);
            end
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (an !== AN_SEQ[(i / 8) % 4]) begin
                errors++;
                $display("[TB] FAIL an_cycle[%0d]: an=%b want %b", i, an, AN_SEQ[(i / 8) % 4]);
            end
        end
    endtask

    task automatic test_frame(string name, int h, int l, bit dt, logic [7:0] want [4]);
        digit_h = 7'(h);
        digit_l = 7'(l);
        dot = dt;
        sync_capture();
        repeat (4) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            if (d > 0) repeat (8) @(negedge clk);
            checks++;
            if (an !== AN_SEQ[d] || seg !== want[d]) begin
                errors++;
                $display("[TB] FAIL %s digit%0d: an=%b seg=%h, want an=%b seg=%h",
                         name, d, an, seg, AN_SEQ[d], want[d]);
            end
        end
    endtask

    task automatic test_digits();
        test_frame("digits_12_34", 12, 34, 1'b0, '{8'h99, 8'hB0, 8'hA4, 8'hF9});
    endtask

    task automatic test_dot();
        test_frame("dot_12_34", 12, 34, 1'b1, '{8'h99, 8'hB0, 8'h24, 8'hF9});
    endtask

    task automatic test_clamp();
        test_frame("clamp_120_7", 120, 7, 1'b0, '{8'hF8, 8'hC0, 8'h90, 8'h90});
    endtask

    task automatic test_lead_zero();
`ifdef FND_LEAD_ZERO_BLANK_EN
        test_frame("lead_zero_5", 5, 0, 1'b0, '{8'hC0, 8'hC0, 8'h92, 8'hFF});
`else
        test_frame("lead_zero_5", 5, 0, 1'b0, '{8'hC0, 8'hC0, 8'h92, 8'hC0});
`endif
    endtask

    task automatic test_mid_frame();
        logic [7:0] want [6];
        want = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'h82, 8'h92};
        digit_h = 7'd12;
        digit_l = 7'd34;
        dot = 1'b0;
        sync_capture();
        repeat (4) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) repeat (8) @(negedge clk);
            if (k == 1) digit_l = 7'd56;
            checks++;
            if (an !== AN_SEQ[k % 4] || seg !== want[k]) begin
                errors++;
                $display("[TB] FAIL mid_frame step%0d: an=%b seg=%h, want an=%b seg=%h",
                         k, an, seg, AN_SEQ[k % 4], want[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] ea;
        logic [7:0] es;
        int hold;
        hold = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            model_expect(ea, es);
            checks++;
            if (an !== ea || seg !== es) begin
                errors++;
                $display("[TB] FAIL random[%0d] n=%0d: an=%b seg=%h, want an=%b seg=%h",
                         i, n, an, seg, ea, es);
            end
            if (hold == 0) begin
                case ($urandom_range(0, 3))
                    0:       digit_h = 7'($urandom_range(98, 101));
                    1:       digit_h = 7'($urandom_range(0, 9));
                    default: digit_h = 7'($urandom_range(0, 127));
                endcase
                digit_l = 7'($urandom_range(0, 127));
                dot = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 20);
            end else begin
                hold--;
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [3:0] ea;
        logic [7:0] es;
        digit_h = 7'd47;
        digit_l = 7'd81;
        dot = 1'b1;
        repeat (13) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (an !== 4'b1111 || seg !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL mid_reset_dark: an=%b seg=%h, want an=1111 seg=ff", an, seg);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            model_expect(ea, es);
            checks++;
            if (an !== ea || seg !== es) begin
                errors++;
                $display("[TB] FAIL restart[%0d]: an=%b seg=%h, want an=%b seg=%h", i, an, seg, ea, es);
            end
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_digits();
        test_dot();
        test_mid_frame();
        test_clamp();
        test_lead_zero();
        test_random();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
- Consumer end of the two-digit-pair time display interface: takes `digit_h` / `digit_l` (binary 0..99 each) and `dot` from the time-select block and drives a 4-digit multiplexed 7-segment (FND) display.
- Converts each pair to two BCD digits, time-multiplexes the four digits at a fixed scan rate and places the blinking dot between the high and low pairs.
- Sits between the time-select block and the board FND pins.

Parameters:
- SYS_HZ, 100_000_000, input clock frequency in Hz.
- SCAN_HZ, 1000, per-digit scan-step rate in Hz; scan period is SYS_HZ/SCAN_HZ clocks; must be >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- digit_h  input  7  high pair value, binary (sec or hour).
- digit_l  input  7  low pair value, binary (ms10 or min).
- dot  input  1  dot request, 1 = lit.
- seg  output  8  segment drive, active-low; seg[6:0] = g..a, seg[7] = dp.
- an  output  4  digit enables, active-low; an[0] = rightmost digit.

Behaviour:
- Reset (reset = 0, asynchronous):
  - scan counter = 0, digit index = 0.
  - Shadow regs (h, l, dot) = 0.
  - an = 4'b1111, seg = 8'hFF (display dark).
  - Outputs hold these values until the first scan tick after reset is released.
- Scan divider:
  - Counter counts 0..SYS_HZ/SCAN_HZ-1, then wraps to 0.
  - A 1-clk scan_tick pulses on the wrap.
  - The counter width is sized by $clog2 of the period.
- Digit index:
  - 2-bit index advances 0→1→2→3→0 on each scan_tick.
- Frame-coherent sampling (no tearing):
  - digit_h, digit_l and dot are captured into shadow regs on the scan_tick that moves the index 3→0.
  - The first capture happens on the first scan_tick after reset.
  - Input changes mid-frame do not appear until the next frame.
- Clamp:
  - A shadow value > 99 is displayed as 99 (saturate, no modulo).
- BCD split:
  - tens = value/10, ones = value%10.
  - Combinational on the shadow regs.
- Digit mapping:
  - idx0 = ones(l), idx1 = tens(l), idx2 = ones(h), idx3 = tens(h).
- Decode:
  - Active-low codes for 0..9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex, seg[7:0] with dp bit = 1).
  - Codes outside 0..9 are unreachable; default = 8'hFF.
- Dot:
  - seg[7] = ~shadow_dot only when idx = 2; otherwise seg[7] = 1.
- Output timing:
  - seg and an are registered and change 1 clk after the index changes.
  - an = ~(4'b0001 << idx).
  - Exactly one an bit is low at any time after the first scan tick.
- Reset mid-scan:
  - Outputs go dark immediately.
  - The scan restarts from idx 0 with count 0 after release.

Optional Feature:
- Macro: FND_LEAD_ZERO_BLANK_EN.
- Defined: when tens(h) = 0, digit idx3 is blanked (an bit still strobes, seg[6:0] = 7'h7F). All other digits are never blanked.
- Undefined: all four digits always show their decoded value, including leading 0.

Test Plan (SYS_HZ = 8, SCAN_HZ = 1 → 8-clk scan step):
- Reset held low 20 clks, then released → an = 1111 and seg = FF until the first tick; then an cycles 1110, 1101, 1011, 0111 every 8 clks, repeating.
- digit_h = 12, digit_l = 34, dot = 0, one full frame → seg = 99 (4) at an 1110, B0 (3) at 1101, A4 (2) at 1011, F9 (1) at 0111.
- dot = 1 with h = 12, l = 34 → seg = 24 (hex, '2' with dp low) at an 1011; all other digits have seg[7] = 1.
- Change l from 34 to 56 while idx = 1 → the current frame still shows 34; the next frame after the 3→0 wrap shows 6 then 5.
- digit_h = 120, digit_l = 7 → h shown as 99 (both 90); l shown as F8 (7) and C0 (0).
- h = 5: with FND_LEAD_ZERO_BLANK_EN, seg = FF at an 0111; without it, seg = C0 at an 0111.
